// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_pkg: shared types and constants for the SoC data bus fabric.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic mid_t;

    localparam int C_DEF_WIDTH    = 32;
    localparam int C_DEF_MAXBURST = 8;

    // Slave address map, shared with the bus decoder
    localparam logic [31:0] C_RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] C_DPRAM_BASE = 32'h0001_0000;
    localparam logic [31:0] C_BTN_BASE   = 32'h0002_0000;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pick: combinational round-robin pick between two requesters.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module arb_pick
    import bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  mid_t last,
    output mid_t winner,
    output logic valid
);

    assign valid  = req0 | req1;
    // On a tie the master that did not win last time goes first
    assign winner = (req0 & req1) ? ~last : req1;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter: two-master round-robin bus arbiter with capped locks.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH    = C_DEF_WIDTH,
    parameter int MAXBURST = C_DEF_MAXBURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_lock,
    input  logic             m0_write,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_lock,
    input  logic             m1_write,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic [WIDTH-1:0] busaddr,
    output logic [WIDTH-1:0] buswdata,
    output logic             buswrite,
    input  logic [WIDTH-1:0] busrdata
);

    localparam logic [7:0] C_MAXCNT = 8'(MAXBURST);

    arb_state_t       r_state, w_state_nxt;
    mid_t             r_last, w_last_nxt;
    logic [7:0]       r_count, w_count_nxt;
    logic             r_rd_valid;
    mid_t             r_rd_id;
    logic [WIDTH-1:0] r_busaddr, r_buswdata;

    logic [1:0]       w_req, w_lock, w_write;
    mid_t             w_owner, w_pick_id, w_gnt_id;
    logic             w_owned, w_forced, w_pick_valid, w_gnt_valid, w_gnt;
    logic [WIDTH-1:0] w_sel_addr, w_sel_wdata;

    assign w_req   = {m1_req, m0_req};
    assign w_lock  = {m1_lock, m0_lock};
    assign w_write = {m1_write, m0_write};

    arb_pick u_pick (
        .req0   (m0_req),
        .req1   (m1_req),
        .last   (r_last),
        .winner (w_pick_id),
        .valid  (w_pick_valid)
    );

    always_comb begin
        w_state_nxt = IDLE;
        w_count_nxt = 8'd0;
        w_last_nxt  = r_last;
        w_owner     = (r_state == OWN1);
        w_owned     = (r_state != IDLE) && w_req[w_owner];
        w_forced    = 1'b0;
        w_gnt_valid = w_pick_valid;
        w_gnt_id    = w_pick_id;
        if (w_owned) begin
            // A full burst hands over only if the other master is waiting
            w_forced    = (r_count == C_MAXCNT) && w_req[~w_owner];
            w_gnt_valid = 1'b1;
            w_gnt_id    = w_forced ? ~w_owner : w_owner;
        end
        if (w_gnt_valid) begin
            w_last_nxt = w_gnt_id;
            if (w_lock[w_gnt_id]) begin
                w_state_nxt = w_gnt_id ? OWN1 : OWN0;
                if (w_owned && !w_forced)
                    w_count_nxt = (r_count == C_MAXCNT) ? r_count : r_count + 8'd1;
                else
                    w_count_nxt = 8'd1;
            end
        end
    end

    assign w_gnt       = w_gnt_valid & ~rst;
    assign w_sel_addr  = w_gnt_id ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt_id ? m1_wdata : m0_wdata;

    assign m0_gnt   = w_gnt & (w_gnt_id == 1'b0);
    assign m1_gnt   = w_gnt & (w_gnt_id == 1'b1);
    assign busaddr  = w_gnt ? w_sel_addr  : r_busaddr;
    assign buswdata = w_gnt ? w_sel_wdata : r_buswdata;
    assign buswrite = w_gnt & w_write[w_gnt_id];

    assign m0_rvalid = r_rd_valid & ~rst & (r_rd_id == 1'b0);
    assign m1_rvalid = r_rd_valid & ~rst & (r_rd_id == 1'b1);
    assign m0_rdata  = busrdata;
    assign m1_rdata  = busrdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_count    <= 8'd0;
            r_rd_valid <= 1'b0;
            r_rd_id    <= 1'b0;
            r_busaddr  <= '0;
            r_buswdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= w_gnt & ~w_write[w_gnt_id];
            r_rd_id    <= w_gnt_id;
            if (w_gnt) begin
                r_busaddr  <= w_sel_addr;
                r_buswdata <= w_sel_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_arbiter: vectors, corner sequences and random traffic vs model.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bus_arbiter;

    localparam int W  = 32;
    localparam int MB = 8;

    logic         clk, rst;
    logic         m0_req, m0_lock, m0_write, m0_gnt, m0_rvalid;
    logic         m1_req, m1_lock, m1_write, m1_gnt, m1_rvalid;
    logic [W-1:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [W-1:0] busaddr, buswdata, busrdata;
    logic         buswrite;

    bus_arbiter #(.WIDTH(W), .MAXBURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_write(m0_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_write(m1_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .busaddr(busaddr), .buswdata(buswdata), .buswrite(buswrite),
        .busrdata(busrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM slave
    logic [W-1:0] mem [256];
    logic [W-1:0] rdq;
    assign busrdata = rdq;
    always @(posedge clk) begin
        rdq <= mem[busaddr[9:2]];
        if (buswrite) mem[busaddr[9:2]] <= buswdata;
    end

    // Reference model state
    int           m_own, m_cnt, m_last, m_pend_id;
    bit           m_pend;
    logic [W-1:0] m_pend_data, m_hold_a, m_hold_d;
    logic [W-1:0] exp_mem [256];

    int           checks, errors;
    logic         s_g0, s_g1, s_rv0, s_rv1, s_bw;
    logic [W-1:0] s_rd1;

    typedef struct {
        bit r0, r1, l0, l1;
        bit eg0, eg1;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_cnt = 0; m_last = 1; m_pend = 0; m_pend_id = 0;
        m_pend_data = '0; m_hold_a = '0; m_hold_d = '0;
    endtask

    task automatic step(input bit rs, input bit r0, input bit r1, input bit l0, input bit l1,
                        input bit w0, input bit w1, input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1, input bit do_chk);
        bit           rq [2];
        bit           lk [2];
        bit           wr [2];
        logic [W-1:0] ad [2];
        logic [W-1:0] wd [2];
        int           g;
        bit           forced;
        logic [W-1:0] e_a, e_d;
        rq[0] = r0; rq[1] = r1; lk[0] = l0; lk[1] = l1; wr[0] = w0; wr[1] = w1;
        ad[0] = a0; ad[1] = a1; wd[0] = d0; wd[1] = d1;
        rst = rs;
        m0_req = r0; m0_lock = l0; m0_write = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_lock = l1; m1_write = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        g = -1; forced = 0;
        if (!rs) begin
            if (m_own >= 0 && rq[m_own]) begin
                if (m_cnt == MB && rq[1-m_own]) begin g = 1 - m_own; forced = 1; end
                else g = m_own;
            end else if (r0 && r1) g = 1 - m_last;
            else if (r0) g = 0;
            else if (r1) g = 1;
        end
        e_a = (g >= 0) ? ad[g] : m_hold_a;
        e_d = (g >= 0) ? wd[g] : m_hold_d;
        if (do_chk) begin
            chk("gnt", {m1_gnt, m0_gnt}, {(g == 1), (g == 0)});
            chk("buswrite", buswrite, (g >= 0) && wr[g]);
            chk("busaddr", busaddr, e_a);
            chk("buswdata", buswdata, e_d);
            chk("rvalid", {m1_rvalid, m0_rvalid},
                {(!rs && m_pend && m_pend_id == 1), (!rs && m_pend && m_pend_id == 0)});
            if (!rs && m_pend && m_pend_id == 0) chk("m0_rdata", m0_rdata, m_pend_data);
            if (!rs && m_pend && m_pend_id == 1) chk("m1_rdata", m1_rdata, m_pend_data);
        end
        s_g0 = m0_gnt; s_g1 = m1_gnt; s_rv0 = m0_rvalid; s_rv1 = m1_rvalid;
        s_bw = buswrite; s_rd1 = m1_rdata;
        @(posedge clk);
        if (rs) model_reset();
        else begin
            m_pend    = (g >= 0) && !wr[g];
            m_pend_id = g;
            if (g >= 0) begin
                m_pend_data = exp_mem[ad[g][9:2]];
                if (wr[g]) exp_mem[ad[g][9:2]] = wd[g];
                m_hold_a = ad[g];
                m_hold_d = wd[g];
                m_last   = g;
                if (g == m_own && !forced) begin
                    if (lk[g]) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                    else begin m_own = -1; m_cnt = 0; end
                end else begin
                    m_own = lk[g] ? g : -1;
                    m_cnt = lk[g] ? 1 : 0;
                end
            end else begin
                m_own = -1; m_cnt = 0;
            end
        end
        #1;
    endtask

    initial begin
        int n1, before_m0, wait0, bw_cnt;
        bit m0_seen;
        checks = 0; errors = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            exp_mem[i] = mem[i];
        end
        model_reset();
        rst = 1'b1;
        m0_req = 0; m0_lock = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with both masters requesting
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1, 0, 0, 0, 0, 32'h10, 32'h20, 0, 0, 1);
            chk("rst_gnt", {s_g1, s_g0}, 2'b00);
            chk("rst_bw_rv", {s_bw, s_rv1, s_rv0}, 3'b000);
        end

        // Arbitration vectors, all reads
        tbl[0] = '{1, 1, 0, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 0, 0, 1};
        tbl[2] = '{1, 1, 0, 0, 1, 0};
        tbl[3] = '{0, 1, 0, 0, 0, 1};
        tbl[4] = '{1, 1, 0, 0, 1, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 0, 1, 0, 1, 0};
        tbl[7] = '{1, 1, 1, 0, 1, 0};
        tbl[8] = '{0, 1, 0, 0, 0, 1};
        tbl[9] = '{1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            step(0, tbl[i].r0, tbl[i].r1, tbl[i].l0, tbl[i].l1, 0, 0,
                 32'h40 + 32'(i * 4), 32'h80 + 32'(i * 4), 0, 0, 1);
            chk("tbl_gnt0", s_g0, tbl[i].eg0);
            chk("tbl_gnt1", s_g1, tbl[i].eg1);
        end

        // Locked burst by m1 with m0 waiting
        step(0, 0, 1, 0, 1, 0, 0, 32'h0, 32'h200, 0, 0, 1);
        n1 = 1; before_m0 = 0; wait0 = 0; m0_seen = 0;
        for (int c = 0; c < 60 && n1 < 20; c++) begin
            step(0, 1, 1, 0, 1, 0, 0, 32'h300, 32'h200 + 32'(c * 4), 0, 0, 1);
            if (s_g1) n1++;
            if (!m0_seen) begin
                wait0++;
                if (s_g0) begin m0_seen = 1; before_m0 = n1; end
            end
        end
        chk("burst_m1_before_m0", before_m0, MB);
        chk("burst_m0_wait_le_max", (m0_seen && wait0 <= MB), 1);
        chk("burst_m1_total", n1, 20);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Write then read of the same word by the other master
        bw_cnt = 0;
        step(0, 1, 0, 0, 0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
        bw_cnt += int'(s_bw);
        step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h100, 0, 0, 1);
        bw_cnt += int'(s_bw);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        bw_cnt += int'(s_bw);
        chk("wr_pulse_count", bw_cnt, 1);
        chk("rd_m1_rvalid", s_rv1, 1);
        chk("rd_m1_rdata", s_rd1, 32'hDEADBEEF);
        chk("rd_m0_rvalid", s_rv0, 0);

        // Reset in the cycle after an accepted locked read
        step(0, 0, 1, 0, 1, 0, 0, 0, 32'h100, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("rstmid_rvalid", {s_rv1, s_rv0}, 2'b00);
        step(0, 1, 1, 0, 0, 0, 0, 32'h8, 32'hC, 0, 0, 1);
        chk("rstmid_idle_m0_first", {s_g1, s_g0}, 2'b01);
        chk("rstmid_no_late_rvalid", {s_rv1, s_rv0}, 2'b00);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) < 3), ($urandom_range(0, 4) < 3),
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                 $urandom & 32'h3FC, $urandom & 32'h3FC, $urandom, $urandom, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter placed in front of the SoC data bus, so the RISC-V core and a second master (the JPEG/UART DMA engine) share the bus and its RAM, dual-port RAM and button slaves. It grants one single-beat transfer per cycle using round-robin priority. Optional locked bursts are capped at MAXBURST beats to prevent starvation. Read data returns one cycle after the transfer is accepted and is steered back to the master that issued it.

## Interface
- WIDTH, 32: address and data width.
- MAXBURST, 8: maximum consecutive locked beats before a forced handover (2..255).

- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- m0_req, m1_req  input  1  transfer request; address, write data and direction must be held stable while req=1 and gnt=0.
- m0_lock, m1_lock  input  1  keep ownership for the next beat, sampled with an accepted beat.
- m0_write, m1_write  input  1  1 = write, 0 = read.
- m0_addr, m1_addr  input  WIDTH  byte address.
- m0_wdata, m1_wdata  input  WIDTH  write data.
- m0_gnt, m1_gnt  output  1  beat accepted this cycle (combinational from state and req).
- m0_rvalid, m1_rvalid  output  1  read data valid, one cycle after an accepted read.
- m0_rdata, m1_rdata  output  WIDTH  both driven from busrdata; valid only with the matching rvalid.
- busaddr  output  WIDTH  address to the bus decoder.
- buswdata  output  WIDTH  write data to the bus.
- buswrite  output  1  write strobe; asserted only during an accepted write beat.
- busrdata  input  WIDTH  slave read data, one cycle after the address (synchronous RAM).

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0: master 0 locked.
  - OWN1: master 1 locked.
- Round-robin register `last` (0/1) records the most recent winner. Its reset value is 1, so master 0 wins the first tie.
- IDLE:
  - Only one req: that master is granted.
  - Both req: the master != last is granted.
  - Winner beat with lock=1: go to OWNx and load the burst count to 1. Otherwise stay IDLE. `last` updates to the winner.
- OWNx:
  - mx_req=1: mx is granted unconditionally unless the burst count == MAXBURST and the other master is requesting.
  - On a forced release: grant the other master this cycle, go to IDLE (or OWNy if its lock=1), and reset the count.
  - Accepted beat with lock=1: increment the count (saturates at MAXBURST).
  - Accepted beat with lock=0: return to IDLE.
  - mx_req=0 while in OWNx: release to IDLE in the same cycle and arbitrate as in IDLE, so there is no dead cycle.
- Bus mux:
  - busaddr and buswdata follow the granted master.
  - With no grant, busaddr and buswdata hold their last value and buswrite=0.
- Read return:
  - Register `rd_pend` (valid plus id) is set for an accepted read.
  - The next cycle drives the matching mx_rvalid=1. At most one read is pending per cycle.
- Writes produce no response. They complete in the grant cycle.

## Timing
- Grant latency: 0 cycles when the bus is free or owned by the requester. Worst case MAXBURST cycles behind a locked burst.
- Read data: rvalid exactly 1 cycle after gnt&!write. Back-to-back reads give rvalid every cycle.
- Simultaneous events:
  - A forced release and the other master's lock in the same cycle: the other master becomes owner and its count starts at 1.
  - The owner drops req while the other master requests: the other master is granted in the same cycle.
- Reset values, and behaviour mid-operation:
  - State IDLE, last=1, count=0, rd_pend cleared (a pending rvalid is dropped).
  - All gnt=0, all rvalid=0, buswrite=0, busaddr=0, buswdata=0.
  - The gnt outputs are forced to 0 while rst=1.

## Structure
- Shared package `bus_pkg`:
  - arb_state_t enum (IDLE, OWN0, OWN1).
  - Master id type (1 bit).
  - Default WIDTH and MAXBURST constants. Slave address map constants are shared with the bus decoder.
- One sub-module, `arb_pick`: combinational round-robin selection (req0, req1, last) -> winner id and valid, reused if more masters are added.

## Test plan
- Reset: hold rst for 2 cycles with both req=1 -> every gnt, rvalid and buswrite stays 0; on the first cycle after reset m0_gnt=1.
- Contention without lock: both masters request reads every cycle -> grants alternate m0, m1, m0, m1. Each mx_rvalid follows 1 cycle later with busrdata routed back.
- Locked burst: m1 holds lock=1 for 20 beats while m0 requests, MAXBURST=8 -> m1 gets 8 beats, m0 gets 1 beat, then m1 resumes. m0 waits no more than 8 cycles.
- Owner drops req: in OWN0, m0_req falls while m1_req=1 -> m1_gnt=1 in that same cycle; no idle cycle appears on the bus.
- Write/read mix: m0 writes 0xDEADBEEF to 0x100, then m1 reads 0x100 -> buswrite is pulsed for exactly one cycle; m1_rvalid=1 with m1_rdata=0xDEADBEEF, and m0_rvalid stays 0.
- Reset mid-read: assert rst in the cycle after an accepted read -> no rvalid appears, and the state returns to IDLE.
